// File: rtl/prelude_uart_tx_if.sv
// Write port from the prelude core's I/O register into the UART transmitter.
// The core side drives the strobe and byte; the transmitter only listens.
interface prelude_uart_tx_if;
   logic       rio_we;
   logic [7:0] rio_data;

   modport master (
      output rio_we,
      output rio_data
   );

   modport slave (
      input rio_we,
      input rio_data
   );
endinterface

// File: rtl/prelude_uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO of bytes written to the core's I/O register.
// Frames are sent back to back while the FIFO has data; status flags are all registered.
module prelude_uart_tx #(
   parameter int CLK_HZ     = 27_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   prelude_uart_tx_if.slave                     rio,
   output logic                                 tx,
   output logic                                 busy,
   output logic                                 empty,
   output logic                                 full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
   output logic                                 overflow
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int LW           = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_empty;
   logic          r_full;
   logic          r_overflow;

   // Serialiser state
   state_t        r_state;
   logic [CW-1:0] r_baud_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_busy;

   state_t        w_state_next;
   logic [CW-1:0] w_baud_next;
   logic [2:0]    w_bit_next;
   logic [7:0]    w_shift_next;
   logic          w_tx_next;
   logic          w_busy_next;
   logic          w_pop;
   logic          w_push;
   logic          w_baud_last;
   logic [7:0]    w_head;
   logic [LW-1:0] w_level_next;

   // full is the registered flag, so a pop on the same edge never rescues a write
   assign w_push      = rio.rio_we && !r_full;
   assign w_baud_last = (r_baud_cnt == BAUD_LAST);
   assign w_head      = r_mem[r_rd_ptr];

   always_comb begin
      w_level_next = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_next = r_level + 1'b1;
         2'b01:   w_level_next = r_level - 1'b1;
         default: w_level_next = r_level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rio.rio_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_level <= w_level_next;
         r_empty <= (w_level_next == '0);
         r_full  <= (w_level_next == LVL_FULL);
         if (rio.rio_we && r_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_baud_cnt <= w_baud_next;
         r_bit_idx  <= w_bit_next;
         r_shift    <= w_shift_next;
         r_tx       <= w_tx_next;
         r_busy     <= w_busy_next;
      end
   end

   // tx/busy are computed one cycle ahead so the line is driven straight from a flop
   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud_cnt;
      w_bit_next   = r_bit_idx;
      w_shift_next = r_shift;
      w_tx_next    = r_tx;
      w_busy_next  = r_busy;
      w_pop        = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx_next   = 1'b1;
            w_busy_next = 1'b0;
            if (!r_empty) begin
               w_pop        = 1'b1;
               w_shift_next = w_head;
               w_baud_next  = '0;
               w_state_next = S_START;
               w_tx_next    = 1'b0;
               w_busy_next  = 1'b1;
            end
         end

         S_START: begin
            if (w_baud_last) begin
               w_baud_next  = '0;
               w_bit_next   = '0;
               w_state_next = S_DATA;
               w_tx_next    = r_shift[0];
            end else begin
               w_baud_next = r_baud_cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (w_baud_last) begin
               w_baud_next  = '0;
               w_shift_next = {1'b0, r_shift[7:1]};
               if (r_bit_idx == 3'd7) begin
                  w_state_next = S_STOP;
                  w_tx_next    = 1'b1;
               end else begin
                  w_bit_next = r_bit_idx + 1'b1;
                  w_tx_next  = r_shift[1];
               end
            end else begin
               w_baud_next = r_baud_cnt + 1'b1;
            end
         end

         S_STOP: begin
            if (w_baud_last) begin
               w_baud_next = '0;
               if (!r_empty) begin
                  w_pop        = 1'b1;
                  w_shift_next = w_head;
                  w_state_next = S_START;
                  w_tx_next    = 1'b0;
                  w_busy_next  = 1'b1;
               end else begin
                  w_state_next = S_IDLE;
                  w_tx_next    = 1'b1;
                  w_busy_next  = 1'b0;
               end
            end else begin
               w_baud_next = r_baud_cnt + 1'b1;
            end
         end

         default: begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   assign tx       = r_tx;
   assign busy     = r_busy;
   assign empty    = r_empty;
   assign full     = r_full;
   assign level    = r_level;
   assign overflow = r_overflow;
endmodule

// File: tb/tb_prelude_uart_tx.sv
// Directed bench for prelude_uart_tx with CLKS_PER_BIT=16 and a 4-entry FIFO.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_prelude_uart_tx;
   localparam int CLK_HZ     = 16;
   localparam int BAUD       = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int CPB        = 16;
   localparam int FRAME      = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx;
   logic       busy;
   logic       empty;
   logic       full;
   logic [2:0] level;
   logic       overflow;
   int         checks = 0;
   int         failures = 0;

   prelude_uart_tx_if rio_bus ();

   prelude_uart_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rio      (rio_bus),
      .tx       (tx),
      .busy     (busy),
      .empty    (empty),
      .full     (full),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Walk frame cycles first..last-1; cycle 0 is the first start-bit cycle.
   task automatic expect_frame(input logic [7:0] b, input int first, input int last,
                               input bit want_empty);
      logic exp_bit;
      for (int i = first; i < last; i++) begin
         int bit_no;
         bit_no = i / CPB;
         if (bit_no == 0)      exp_bit = 1'b0;
         else if (bit_no == 9) exp_bit = 1'b1;
         else                  exp_bit = b[bit_no-1];
         chk($sformatf("tx_%02h_cyc%0d", b, i), tx, exp_bit);
         chk($sformatf("busy_%02h_cyc%0d", b, i), busy, 1);
         if (want_empty) chk($sformatf("empty_%02h_cyc%0d", b, i), empty, 1);
         tick();
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      rio_bus.rio_we   = 1'b1;
      rio_bus.rio_data = b;
      tick();
      rio_bus.rio_we   = 1'b0;
   endtask

   initial begin
      rio_bus.rio_we   = 1'b0;
      rio_bus.rio_data = 8'h00;

      // 1. reset held 3 cycles
      reset = 1'b1;
      tick(); tick(); tick();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      reset = 1'b0;
      tick(); tick();
      chk("idle_tx", tx, 1);

      // 2. single byte 0xA5
      write_byte(8'hA5);
      chk("t2_level_after_push", level, 1);
      chk("t2_empty_after_push", empty, 0);
      chk("t2_tx_before_pop", tx, 1);
      chk("t2_busy_before_pop", busy, 0);
      tick();
      chk("t2_level_after_pop", level, 0);
      expect_frame(8'hA5, 0, FRAME, 1'b1);
      chk("t2_busy_low", busy, 0);
      chk("t2_tx_idle", tx, 1);
      tick(); tick();
      chk("t2_tx_idle_later", tx, 1);

      // 3. two bytes on consecutive cycles, frames back to back
      write_byte(8'h01);
      write_byte(8'h02);
      chk("t3_level_push_pop", level, 1);
      expect_frame(8'h01, 0, FRAME, 1'b0);
      chk("t3_level_second_start", level, 0);
      expect_frame(8'h02, 0, FRAME, 1'b1);
      chk("t3_busy_low", busy, 0);
      chk("t3_tx_idle", tx, 1);
      tick(); tick();

      // 4. six writes into a 4-deep FIFO: last one dropped
      write_byte(8'h10);
      chk("t4_level_1", level, 1);
      write_byte(8'h11);
      chk("t4_level_1b", level, 1);
      chk("t4_tx_start", tx, 0);
      write_byte(8'h12);
      chk("t4_level_2", level, 2);
      write_byte(8'h13);
      chk("t4_level_3", level, 3);
      chk("t4_not_full", full, 0);
      write_byte(8'h14);
      chk("t4_level_4", level, 4);
      chk("t4_full", full, 1);
      chk("t4_no_overflow_yet", overflow, 0);
      write_byte(8'h15);
      chk("t4_level_still_4", level, 4);
      chk("t4_overflow", overflow, 1);
      chk("t4_still_full", full, 1);
      expect_frame(8'h10, 4, FRAME, 1'b0);
      chk("t4_level_after_f0", level, 3);
      chk("t4_full_cleared", full, 0);
      expect_frame(8'h11, 0, FRAME, 1'b0);
      chk("t4_level_after_f1", level, 2);
      expect_frame(8'h12, 0, FRAME, 1'b0);
      chk("t4_level_after_f2", level, 1);
      expect_frame(8'h13, 0, FRAME, 1'b0);
      chk("t4_level_after_f3", level, 0);
      expect_frame(8'h14, 0, FRAME, 1'b1);
      chk("t4_busy_low", busy, 0);
      chk("t4_tx_idle", tx, 1);
      chk("t4_overflow_sticky", overflow, 1);
      tick(); tick();
      chk("t4_no_extra_frame", tx, 1);

      // 5. push coinciding with a frame-boundary pop at level 2
      write_byte(8'h3C);
      write_byte(8'hC3);
      write_byte(8'h5A);
      chk("t5_level_2", level, 2);
      expect_frame(8'h3C, 1, FRAME - 1, 1'b0);
      chk("t5_tx_last_stop", tx, 1);
      write_byte(8'hE7);
      chk("t5_level_kept_2", level, 2);
      expect_frame(8'hC3, 0, FRAME, 1'b0);
      chk("t5_level_1", level, 1);
      expect_frame(8'h5A, 0, FRAME, 1'b0);
      chk("t5_level_0", level, 0);
      expect_frame(8'hE7, 0, FRAME, 1'b1);
      chk("t5_busy_low", busy, 0);
      tick(); tick();

      // 6. reset at frame cycle 50 with a byte still queued
      write_byte(8'h00);
      write_byte(8'h88);
      chk("t6_level_1", level, 1);
      expect_frame(8'h00, 0, 50, 1'b0);
      chk("t6_tx_low_cyc50", tx, 0);
      reset = 1'b1;
      tick();
      chk("t6_tx_after_reset", tx, 1);
      chk("t6_busy_after_reset", busy, 0);
      chk("t6_level_after_reset", level, 0);
      chk("t6_empty_after_reset", empty, 1);
      chk("t6_overflow_after_reset", overflow, 0);
      reset = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         chk($sformatf("t6_quiet_cyc%0d", i), tx, 1);
      end
      chk("t6_busy_quiet", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
